// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl: PS/2 device-to-host receive controller.
//   Synchronizes and glitch-filters the raw PS/2 pins, sequences the 11-bit
//   frame (start, 8 data LSB first, odd parity, stop) and buffers good
//   scancodes in a small FIFO with a valid/ready handshake.
//   Optional macro PS2_EXT_DECODE_EN: absorbs E0/F0 prefix bytes into
//   ext/brk tags stored alongside each FIFO entry.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   ps_clk, ps_data raw asynchronous PS/2 pins
//   code/brk/ext    head entry (brk/ext tied 0 without the macro)
//   code_valid      FIFO not empty; code_ready pops the head
//   frame_err       one-cycle pulse per discarded frame or timeout
//   overflow        one-cycle pulse when a good byte is dropped (FIFO full)
//   fifo_count      current FIFO occupancy
module ps2_rx_ctrl #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps_clk,
  input  logic                          ps_data,
  output logic [7:0]                    code,
  output logic                          brk,
  output logic                          ext,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

`ifdef PS2_EXT_DECODE_EN
  localparam int W = 10;
`else
  localparam int W = 8;
`endif
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Pin synchronizers (reset to the idle-high bus level)
  logic [1:0] clk_sync, data_sync;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps_clk};
      data_sync <= {data_sync[0], ps_data};
    end
  end

  // Clock glitch filter; a falling accepted edge is the sample event
  logic          clk_filt, sample_ev, sample_bit;
  logic [FW-1:0] filt_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_filt   <= 1'b1;
      filt_cnt   <= '0;
      sample_ev  <= 1'b0;
      sample_bit <= 1'b0;
    end else begin
      sample_ev <= 1'b0;
      if (clk_sync[1] != clk_filt) begin
        if (filt_cnt == FILT_LAST) begin
          clk_filt   <= clk_sync[1];
          filt_cnt   <= '0;
          sample_ev  <= clk_filt;
          sample_bit <= data_sync[1];
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Frame sequencer
  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bitcnt;
  logic          par_err;
  logic [TW-1:0] to_cnt;
  logic          good_stop, bad_sample, timeout;

  always_comb begin
    good_stop  = sample_ev && (state == STOP) && sample_bit && !par_err;
    bad_sample = sample_ev && (((state == IDLE) && sample_bit) ||
                               ((state == STOP) && !(sample_bit && !par_err)));
    timeout    = !sample_ev && (state != IDLE) && (to_cnt == TO_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift     <= '0;
      bitcnt    <= '0;
      par_err   <= 1'b0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad_sample | timeout;
      if (sample_ev) begin
        to_cnt <= '0;
        case (state)
          IDLE: if (!sample_bit) begin
            state   <= DATA;
            bitcnt  <= '0;
            par_err <= 1'b0;
          end
          DATA: begin
            shift  <= {sample_bit, shift[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_err <= ~(sample_bit ^ (^shift));
            state   <= STOP;
          end
          STOP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end else if (timeout) begin
        state  <= IDLE;
        to_cnt <= '0;
      end else if (state != IDLE) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Push generation (prefix decode when enabled)
  logic         push;
  logic [W-1:0] push_data;
`ifdef PS2_EXT_DECODE_EN
  logic ext_pend, brk_pend;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push      <= 1'b0;
      push_data <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
    end else begin
      push <= 1'b0;
      if (bad_sample || timeout) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (good_stop) begin
        if (shift == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shift == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          push      <= 1'b1;
          push_data <= {brk_pend, ext_pend, shift};
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push      <= 1'b0;
      push_data <= '0;
    end else begin
      push <= good_stop;
      if (good_stop) push_data <= shift;
    end
  end
`endif

  // Scancode FIFO. The head is held in a register so code/brk/ext are
  // registered; head_next forwards push_data when the write lands on the
  // slot that becomes the new head.
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] count, count_next;
  logic [W-1:0]  head, head_next;
  logic          pop, full, do_push;

  always_comb begin
    pop      = code_valid & code_ready;
    full     = (count == FULL_CNT);
    do_push  = push && (!full || pop);
    rd_next  = pop ? rd_ptr + 1'b1 : rd_ptr;
    case ({do_push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
    head_next = (do_push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      code_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr     <= rd_next;
      count      <= count_next;
      head       <= head_next;
      code_valid <= (count_next != '0);
      overflow   <= push && full && !pop;
    end
  end

  assign code       = head[7:0];
  assign fifo_count = count;
`ifdef PS2_EXT_DECODE_EN
  assign brk = head[9];
  assign ext = head[8];
`else
  assign brk = 1'b0;
  assign ext = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
module tb_ps2_rx_ctrl;
  localparam int HALF  = 20;
  localparam int TO    = 2000;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, reset = 1'b1;
  logic       ps_clk = 1'b1, ps_data = 1'b1, code_ready = 1'b0;
  logic [7:0] code;
  logic       brk, ext, code_valid, frame_err, overflow;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  ps2_rx_ctrl #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps_clk    (ps_clk),
    .ps_data   (ps_data),
    .code      (code),
    .brk       (brk),
    .ext       (ext),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  int checks = 0, errors = 0, ferr_n = 0, ovf_n = 0, f0, o0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses and checks each popped entry against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) ferr_n++;
      if (overflow) ovf_n++;
      if (code_valid && code_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h expected none", {brk, ext, code});
        end else begin
          mon_exp = exp_q.pop_front();
          check("pop_entry", int'({brk, ext, code}), int'(mon_exp));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps_data = b;
    tick(HALF);
    ps_clk = 1'b0;
    tick(HALF);
    ps_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_par);
    send_bit(1'b1);
    ps_data = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic expect_code(input logic b, input logic e, input logic [7:0] c);
    exp_q.push_back({b, e, c});
  endtask

  task automatic drain();
    code_ready = 1'b1;
    for (int i = 0; i < 40 && fifo_count != 0; i++) tick(1);
    check("drain_empty", fifo_count, 0);
    code_ready = 1'b0;
    tick(2);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    // Reset values
    tick(3);
    check("rst_code", code, 0);
    check("rst_brk", brk, 0);
    check("rst_ext", ext, 0);
    check("rst_valid", code_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    tick(5);

    // Single good frame, held then popped with a one-cycle ready
    expect_code(1'b0, 1'b0, 8'h1C);
    send_byte(8'h1C, 1'b0);
    check("t1_valid", code_valid, 1);
    check("t1_count", fifo_count, 1);
    check("t1_code", code, 8'h1C);
    check("t1_no_ferr", ferr_n, 0);
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
    tick(2);
    check("t1_count_after_pop", fifo_count, 0);

    // Break prefix
`ifdef PS2_EXT_DECODE_EN
    expect_code(1'b1, 1'b0, 8'h1C);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    check("t2_count", fifo_count, 1);
`else
    expect_code(1'b0, 1'b0, 8'hF0);
    expect_code(1'b0, 1'b0, 8'h1C);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    check("t2_count", fifo_count, 2);
`endif
    drain();

    // Parity error, then recovery
    f0 = ferr_n;
    send_byte(8'h1C, 1'b1);
    check("t3_parity_ferr", ferr_n - f0, 1);
    check("t3_count", fifo_count, 0);
    expect_code(1'b0, 1'b0, 8'h32);
    send_byte(8'h32, 1'b0);
    check("t3_count_good", fifo_count, 1);
    drain();

    // Timeout mid-frame, then recovery
    f0 = ferr_n;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    ps_data = 1'b1;
    tick(TO + 200);
    check("t4_timeout_ferr", ferr_n - f0, 1);
    expect_code(1'b0, 1'b0, 8'h1C);
    send_byte(8'h1C, 1'b0);
    drain();

    // Overflow with depth 4
    o0 = ovf_n;
    f0 = ferr_n;
    expect_code(1'b0, 1'b0, 8'h15);
    expect_code(1'b0, 1'b0, 8'h1D);
    expect_code(1'b0, 1'b0, 8'h24);
    expect_code(1'b0, 1'b0, 8'h2D);
    send_byte(8'h15, 1'b0);
    send_byte(8'h1D, 1'b0);
    send_byte(8'h24, 1'b0);
    send_byte(8'h2D, 1'b0);
    check("t5_full_count", fifo_count, 4);
    check("t5_no_ovf_yet", ovf_n - o0, 0);
    send_byte(8'h2C, 1'b0);
    check("t5_ovf_pulse", ovf_n - o0, 1);
    check("t5_count_after_ovf", fifo_count, 4);
    check("t5_head", code, 8'h15);
    check("t5_no_ferr", ferr_n - f0, 0);
    drain();

    // Reset mid-frame with an entry buffered
    send_byte(8'h1C, 1'b0);
    check("t6_count_before", fifo_count, 1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    reset = 1'b1;
    #1;
    check("t6_rst_code", code, 0);
    check("t6_rst_valid", code_valid, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_ferr", frame_err, 0);
    check("t6_rst_ovf", overflow, 0);
    ps_clk  = 1'b1;
    ps_data = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(5);
    expect_code(1'b0, 1'b0, 8'h1C);
    send_byte(8'h1C, 1'b0);
    check("t6_count_after", fifo_count, 1);
    drain();

    tick(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
